// File: rtl/exu_commit_bjp_if.sv
// Commit and flush/redirect signal bundle between exu_alu_bjp, the commit stage and the IFU.
// master: upstream producer and IFU side; slave: the commit stage.
interface exu_commit_bjp_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_SIZE = 32
);
  logic               cmt_i_valid;
  logic               cmt_i_ready;
  logic               cmt_i_bjp;
  logic               cmt_i_jalr;
  logic               cmt_i_bjp_prdt;
  logic               cmt_i_bjp_rslv;
  logic [PC_SIZE-1:0] cmt_i_pc;
  logic [XLEN-1:0]    cmt_i_imm;
  logic [XLEN-1:0]    cmt_i_rs1;
  logic               flush_req;
  logic               flush_ack;
  logic [PC_SIZE-1:0] flush_pc;
  logic               cmt_o_mispred;

  modport master (
    output cmt_i_valid, cmt_i_bjp, cmt_i_jalr, cmt_i_bjp_prdt, cmt_i_bjp_rslv,
    output cmt_i_pc, cmt_i_imm, cmt_i_rs1, flush_ack,
    input  cmt_i_ready, flush_req, flush_pc, cmt_o_mispred
  );

  modport slave (
    input  cmt_i_valid, cmt_i_bjp, cmt_i_jalr, cmt_i_bjp_prdt, cmt_i_bjp_rslv,
    input  cmt_i_pc, cmt_i_imm, cmt_i_rs1, flush_ack,
    output cmt_i_ready, flush_req, flush_pc, cmt_o_mispred
  );
endinterface

// File: rtl/exu_commit_bjp.sv
// Branch/jump commit stage: retires commits, detects mispredicts and drives the IFU flush handshake.
// Define BJP_PERF_CNT_EN to add the perf_bjp_cnt / perf_mispred_cnt event counters.
module exu_commit_bjp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  exu_commit_bjp_if.slave bus
`ifdef BJP_PERF_CNT_EN
  ,
  output logic [31:0]     perf_bjp_cnt,
  output logic [31:0]     perf_mispred_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e             r_state;
  logic               r_ready;
  logic               r_flush_req;
  logic               r_mispred;
  logic [PC_SIZE-1:0] r_flush_pc;

  logic               w_accept;
  logic               w_mispred;
  logic [XLEN-1:0]    w_jalr_sum;
  logic [PC_SIZE-1:0] w_target;

  // JALR is never predicted by the IFU, so every JALR commit redirects
  assign w_accept   = bus.cmt_i_valid & r_ready;
  assign w_mispred  = bus.cmt_i_bjp &
                      (bus.cmt_i_jalr | (bus.cmt_i_bjp_prdt != bus.cmt_i_bjp_rslv));
  assign w_jalr_sum = bus.cmt_i_rs1 + bus.cmt_i_imm;

  // Resolved target; not-taken falls through to pc+4
  always_comb begin
    w_target = bus.cmt_i_pc + PC_SIZE'(4);
    if (bus.cmt_i_bjp_rslv) begin
      if (bus.cmt_i_jalr) begin
        w_target = PC_SIZE'(w_jalr_sum) & ~PC_SIZE'(1);
      end else begin
        w_target = bus.cmt_i_pc + PC_SIZE'(bus.cmt_i_imm);
      end
    end
  end

  // Flush FSM; ready is held as a register mirroring state==IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_flush_req <= 1'b0;
      r_flush_pc  <= '0;
      r_mispred   <= 1'b0;
    end else begin
      r_mispred <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_mispred) begin
            r_state     <= ST_FLUSH;
            r_ready     <= 1'b0;
            r_flush_req <= 1'b1;
            r_flush_pc  <= w_target;
            r_mispred   <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (bus.flush_ack) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_flush_req <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_flush_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmt_i_ready   = r_ready;
  assign bus.flush_req     = r_flush_req;
  assign bus.flush_pc      = r_flush_pc;
  assign bus.cmt_o_mispred = r_mispred;

`ifdef BJP_PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_bjp_cnt;
  logic [CNT_W-1:0] r_perf_mispred_cnt;

  // Free-running event counters, wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_bjp_cnt     <= '0;
      r_perf_mispred_cnt <= '0;
    end else begin
      if (w_accept && bus.cmt_i_bjp) begin
        r_perf_bjp_cnt <= r_perf_bjp_cnt + CNT_W'(1);
      end
      if (w_accept && w_mispred) begin
        r_perf_mispred_cnt <= r_perf_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign perf_bjp_cnt     = r_perf_bjp_cnt;
  assign perf_mispred_cnt = r_perf_mispred_cnt;
`endif

endmodule

// File: tb/tb_exu_commit_bjp.sv
// Self-checking bench for exu_commit_bjp: directed scenarios then randomized traffic vs a transaction model.
// Counter checks are active when BJP_PERF_CNT_EN is defined.
module tb_exu_commit_bjp;

  logic clk;
  logic rst;

  exu_commit_bjp_if #(.XLEN(32), .PC_SIZE(32)) bif ();

`ifdef BJP_PERF_CNT_EN
  logic [31:0] perf_bjp_cnt;
  logic [31:0] perf_mispred_cnt;
  exu_commit_bjp dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bif),
    .perf_bjp_cnt     (perf_bjp_cnt),
    .perf_mispred_cnt (perf_mispred_cnt)
  );
`else
  exu_commit_bjp dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Transaction-level model: is a redirect outstanding, its target, pulse and event counts
  bit          m_busy  = 1'b0;
  logic [31:0] m_pc    = '0;
  bit          m_pulse = 1'b0;
  logic [31:0] m_bjp   = '0;
  logic [31:0] m_mis   = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_mispred(input bit bjp, input bit jalr, input bit prdt, input bit rslv);
    return bjp && (jalr || (prdt != rslv));
  endfunction

  function automatic logic [31:0] ref_target(input bit jalr, input bit rslv,
                                              input logic [31:0] pc, input logic [31:0] imm,
                                              input logic [31:0] rs1);
    logic [31:0] t;
    if (!rslv)     t = pc + 32'd4;
    else if (jalr) begin
      t = rs1 + imm;
      t = t - (t % 32'd2);
    end
    else           t = pc + imm;
    return t;
  endfunction

  // One clock: drive at negedge, advance the model at the edge, check just after it
  task automatic cyc(input bit rst_v, input bit valid, input bit bjp, input bit jalr,
                     input bit prdt, input bit rslv, input logic [31:0] pc,
                     input logic [31:0] imm, input logic [31:0] rs1, input bit ack);
    rst                = rst_v;
    bif.cmt_i_valid    = valid;
    bif.cmt_i_bjp      = bjp;
    bif.cmt_i_jalr     = jalr;
    bif.cmt_i_bjp_prdt = prdt;
    bif.cmt_i_bjp_rslv = rslv;
    bif.cmt_i_pc       = pc;
    bif.cmt_i_imm      = imm;
    bif.cmt_i_rs1      = rs1;
    bif.flush_ack      = ack;
    #1;
    chk("ready_at_drive", 64'(bif.cmt_i_ready), 64'(!m_busy));
    @(posedge clk);
    m_pulse = 1'b0;
    if (rst_v) begin
      m_busy = 1'b0;
      m_pc   = '0;
      m_bjp  = '0;
      m_mis  = '0;
    end else if (m_busy) begin
      if (ack) m_busy = 1'b0;
    end else if (valid) begin
      if (bjp) m_bjp = m_bjp + 32'd1;
      if (ref_mispred(bjp, jalr, prdt, rslv)) begin
        m_busy  = 1'b1;
        m_pc    = ref_target(jalr, rslv, pc, imm, rs1);
        m_pulse = 1'b1;
        m_mis   = m_mis + 32'd1;
      end
    end
    #1;
    chk("flush_req", 64'(bif.flush_req), 64'(m_busy));
    chk("ready", 64'(bif.cmt_i_ready), 64'(!m_busy));
    chk("mispred_pulse", 64'(bif.cmt_o_mispred), 64'(m_pulse));
    if (m_busy || rst_v) chk("flush_pc", 64'(bif.flush_pc), 64'(m_pc));
`ifdef BJP_PERF_CNT_EN
    chk("perf_bjp_cnt", 64'(perf_bjp_cnt), 64'(m_bjp));
    chk("perf_mispred_cnt", 64'(perf_mispred_cnt), 64'(m_mis));
`endif
    @(negedge clk);
  endtask

  task automatic idle(input bit ack);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, ack);
  endtask

  initial begin
    rst = 1'b1;
    bif.cmt_i_valid = 1'b0; bif.cmt_i_bjp = 1'b0; bif.cmt_i_jalr = 1'b0;
    bif.cmt_i_bjp_prdt = 1'b0; bif.cmt_i_bjp_rslv = 1'b0;
    bif.cmt_i_pc = '0; bif.cmt_i_imm = '0; bif.cmt_i_rs1 = '0; bif.flush_ack = 1'b0;
    @(negedge clk);

    // Reset for two cycles
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("reset_flush_pc", 64'(bif.flush_pc), 64'h0);

    // Correctly predicted taken branch retires without a flush
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'h20, '0, 1'b0);
    chk("t2_no_flush", 64'(bif.flush_req), 64'h0);

    // Mispredicted not-taken branch; ack after three held cycles
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h20, '0, 1'b0);
    chk("t3_flush_pc", 64'(bif.flush_pc), 64'h8000_0014);
    idle(1'b0);
    chk("t3_pulse_gone", 64'(bif.cmt_o_mispred), 64'h0);
    idle(1'b0);
    idle(1'b1);
    chk("t3_req_low", 64'(bif.flush_req), 64'h0);

    // JALR always flushes, clears bit0; a following ALU commit stalls until after ack
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0100, 32'h4, 32'h8000_1003, 1'b0);
    chk("t4_flush_pc", 64'(bif.flush_pc), 64'h8000_1006);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0104, '0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0104, '0, '0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0104, '0, '0, 1'b0);

    // Ack in IDLE is ignored
    idle(1'b1);

    // Reset while flushing discards the redirect
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0200, 32'h40, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("t5_req_low", 64'(bif.flush_req), 64'h0);
    chk("t5_ready", 64'(bif.cmt_i_ready), 64'h1);

`ifdef BJP_PERF_CNT_EN
    // Three branches (one mispredict) and two ALU ops
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'h20, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0014, '0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0018, 32'h20, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_001c, '0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0020, 32'h20, '0, 1'b0);
    idle(1'b1);
    chk("t6_bjp_cnt", 64'(perf_bjp_cnt), 64'd3);
    chk("t6_mis_cnt", 64'(perf_mispred_cnt), 64'd1);
    force dut.r_perf_bjp_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_bjp_cnt;
    m_bjp = 32'hFFFF_FFFF;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0030, 32'h8, '0, 1'b0);
    chk("t6_wrap", 64'(perf_bjp_cnt), 64'h0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r_rst, r_val, r_bjp, r_jalr, r_prdt, r_rslv, r_ack;
      r_rst  = ($urandom_range(0, 49) == 0);
      r_val  = ($urandom_range(0, 3) != 0);
      r_bjp  = ($urandom_range(0, 1) == 1);
      r_jalr = r_bjp && ($urandom_range(0, 3) == 0);
      r_prdt = ($urandom_range(0, 1) == 1);
      r_rslv = ($urandom_range(0, 1) == 1);
      r_ack  = ($urandom_range(0, 2) == 0);
      cyc(r_rst, r_val, r_bjp, r_jalr, r_prdt, r_rslv, $urandom, $urandom, $urandom, r_ack);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
